// File: rtl/button_press_classifier_if.sv
// rtl/button_press_classifier_if.sv - button level in, classified single-cycle events out
interface button_press_classifier_if #(
    parameter int CNT_BITS = 24
);
    logic                debounced;
    logic [CNT_BITS-1:0] long_value;
    logic [CNT_BITS-1:0] repeat_value;
    logic                press;
    logic                release_event;
    logic                short_press;
    logic                long_press;
    logic                repeat_event;
    logic                held;

    modport master (
        output debounced, long_value, repeat_value,
        input  press, release_event, short_press, long_press, repeat_event, held
    );

    modport slave (
        input  debounced, long_value, repeat_value,
        output press, release_event, short_press, long_press, repeat_event, held
    );
endinterface

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - press/release/short/long/auto-repeat event classifier
module button_press_classifier #(
    parameter int CNT_BITS = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    button_press_classifier_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt, cnt_inc;
    logic                d_q;
    logic                rise, fall, long_hit, rep_hit;

    logic press_q, release_q, short_q, long_q, repeat_q, held_q;
    logic press_nxt, release_nxt, short_nxt, long_nxt, repeat_nxt, held_nxt;

    assign rise = bus.debounced & ~d_q;
    assign fall = ~bus.debounced & d_q;

    // Saturating increment: a very long hold must never wrap back below a threshold.
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_BITS'(1);
    assign long_hit = (bus.long_value != '0) && (cnt >= bus.long_value - CNT_BITS'(1));
    assign rep_hit  = (bus.repeat_value != '0) && (cnt >= bus.repeat_value - CNT_BITS'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            d_q       <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            d_q       <= bus.debounced;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            short_q   <= short_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            held_q    <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                // A fall on the threshold edge wins: the press is still classified short.
                if (fall) begin
                    state_nxt = IDLE;
                end else if (long_hit) begin
                    state_nxt = LONG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LONG: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else if (rep_hit) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        press_nxt   = (state == IDLE) && rise;
        release_nxt = (state != IDLE) && fall;
        short_nxt   = (state == PRESSED) && fall;
        long_nxt    = (state == PRESSED) && !fall && long_hit;
        repeat_nxt  = (state == LONG) && !fall && rep_hit;
        held_nxt    = (state_nxt != IDLE);
    end

    assign bus.press         = press_q;
    assign bus.release_event = release_q;
    assign bus.short_press   = short_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_event  = repeat_q;
    assign bus.held          = held_q;
endmodule
